// File: rtl/pixel_readout_pkg.sv
// Shared configuration and types for the pixel array readout path.
package pixel_readout_pkg;

  localparam int unsigned PIXEL_ARRAY_HEIGHT = 2;
  localparam int unsigned PIXEL_ARRAY_WIDTH  = 2;
  localparam int unsigned PIXEL_BITS         = 8;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    STREAM,
    DONE
  } readout_state_t;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

endpackage

// File: rtl/pixel_readout.sv
// Row-by-row readout controller: strobes one row, waits for the column bus to
// settle, latches the row, then streams its pixels over valid/ready.
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int unsigned HEIGHT        = PIXEL_ARRAY_HEIGHT,
  parameter int unsigned WIDTH         = PIXEL_ARRAY_WIDTH,
  parameter int unsigned BITS          = PIXEL_BITS,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  output logic [HEIGHT-1:0]             READ,
  input  logic [WIDTH-1:0][BITS-1:0]    DATA_IN,
  output logic [BITS-1:0]               pix_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0] pix_row,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]   pix_col,
  output logic                          pix_last,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SW = 4;

  readout_state_t             state_q, state_d;
  logic [RW-1:0]              row_q, row_d;
  logic [CW-1:0]              col_q, col_d;
  logic [SW-1:0]              settle_q, settle_d;
  logic [WIDTH-1:0][BITS-1:0] buf_q, buf_d;
  logic [HEIGHT-1:0]          read_q, read_d;
  logic [BITS-1:0]            data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       last_q, last_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  // State and output registers; reset clears everything including the row buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      settle_q <= '0;
      buf_q    <= '0;
      read_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      settle_q <= settle_d;
      buf_q    <= buf_d;
      read_q   <= read_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead so they leave registers.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    settle_d = settle_q;
    buf_d    = buf_q;
    read_d   = read_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = SELECT;
          row_d    = '0;
          col_d    = '0;
          settle_d = '0;
          read_d   = HEIGHT'(1);
        end
      end
      SELECT: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          // Capture on the last strobed cycle, while READ is still high.
          buf_d    = DATA_IN;
          state_d  = STREAM;
          read_d   = '0;
          settle_d = '0;
          valid_d  = 1'b1;
          data_d   = DATA_IN[col_q];
          last_d   = (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      STREAM: begin
        if (pix_ready) begin
          if (col_q != CW'(WIDTH - 1)) begin
            col_d  = col_q + CW'(1);
            data_d = buf_q[col_d];
            last_d = (row_q == RW'(HEIGHT - 1)) && (col_d == CW'(WIDTH - 1));
          end else if (row_q != RW'(HEIGHT - 1)) begin
            col_d   = '0;
            row_d   = row_q + RW'(1);
            state_d = SELECT;
            read_d  = HEIGHT'(1) << row_d;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a handshake in the same cycle.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      row_d    = '0;
      col_d    = '0;
      settle_d = '0;
      read_d   = '0;
      valid_d  = 1'b0;
      last_d   = 1'b0;
      done_d   = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign READ      = read_q;
  assign pix_data  = data_q;
  assign pix_valid = valid_q;
  assign pix_row   = row_q;
  assign pix_col   = col_q;
  assign pix_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pixel_readout.sv
// Self-checking bench for pixel_readout: array model, pixel scoreboard, protocol monitor.
module tb_pixel_readout;

  localparam int unsigned H = 2;
  localparam int unsigned W = 2;
  localparam int unsigned B = 8;
  localparam int unsigned S = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 abort;
  logic                 pix_ready;
  logic [H-1:0]         READ;
  logic [W-1:0][B-1:0]  DATA_IN;
  logic [B-1:0]         pix_data;
  logic                 pix_valid;
  logic [0:0]           pix_row;
  logic [0:0]           pix_col;
  logic                 pix_last;
  logic                 busy;
  logic                 done;

  typedef struct {
    int row;
    int col;
    bit last;
    int data;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int pix_cnt  = 0;

  // monitor history
  int           run = 0;
  logic [H-1:0] read_prev = '0;
  bit           stall_prev = 0;
  bit           last_hs_prev = 0;
  logic [B-1:0] data_prev;
  logic [0:0]   row_prev, col_prev;
  logic         lastf_prev;

  pixel_readout #(
    .HEIGHT(H), .WIDTH(W), .BITS(B), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .READ(READ), .DATA_IN(DATA_IN),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_row(pix_row), .pix_col(pix_col), .pix_last(pix_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pixel array model: selected row drives the bus, otherwise junk.
  always_comb begin
    for (int c = 0; c < W; c++) DATA_IN[c] = 8'hEE;
    for (int r = 0; r < H; r++)
      if (READ[r])
        for (int c = 0; c < W; c++) DATA_IN[c] = 8'(16 * (r + 1) + c);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        e.row  = r;
        e.col  = c;
        e.last = (r == H - 1) && (c == W - 1);
        e.data = 16 * (r + 1) + c;
        sb_q.push_back(e);
      end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_valid_row(input string tag, input int row);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pix_valid && (int'(pix_row) == row)) break;
    end
    check_eq(tag, 32'(pix_valid), 32'd1);
  endtask

  task automatic wait_frame(input string tag, input int exp_pix, input int d0, input int p0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (done_cnt > d0) break;
    end
    repeat (6) @(negedge clk);
    #1;
    check_eq({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tag, "_pix_cnt"}, 32'(pix_cnt - p0), 32'(exp_pix));
    check_eq({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    check_eq({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  // Protocol monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      run = 0;
      read_prev = '0;
      stall_prev = 0;
      last_hs_prev = 0;
    end else begin
      check_eq("read_onehot0", 32'($onehot0(READ)), 32'd1);
      if (READ != '0) begin
        if (run != 0 && READ != read_prev) begin
          check_eq("read_len", 32'(run), 32'(S));
          run = 0;
        end
        run++;
      end else if (run != 0) begin
        check_eq("read_len", 32'(run), 32'(S));
        run = 0;
      end
      read_prev = READ;

      if (stall_prev && pix_valid) begin
        check_eq("hold_data", 32'(pix_data), 32'(data_prev));
        check_eq("hold_rowcol", {30'd0, pix_row, pix_col}, {30'd0, row_prev, col_prev});
        check_eq("hold_last", 32'(pix_last), 32'(lastf_prev));
      end

      if (pix_valid && pix_ready) begin
        pix_cnt++;
        check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_eq("pix_data", 32'(pix_data), 32'(e.data));
          check_eq("pix_row", 32'(pix_row), 32'(e.row));
          check_eq("pix_col", 32'(pix_col), 32'(e.col));
          check_eq("pix_last", 32'(pix_last), 32'(e.last));
        end
      end

      if (done) begin
        done_cnt++;
        check_eq("done_after_last", 32'(last_hs_prev), 32'd1);
      end

      last_hs_prev = pix_valid && pix_ready && pix_last;
      stall_prev   = pix_valid && !pix_ready;
      data_prev    = pix_data;
      row_prev     = pix_row;
      col_prev     = pix_col;
      lastf_prev   = pix_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_read", 32'(READ), 32'd0);
    check_eq("rst_valid", 32'(pix_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // abort alone and abort+start in IDLE do nothing
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check_eq("idle_abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 begin abort = 1'b1; start = 1'b1; end
    @(posedge clk); #1 begin abort = 1'b0; start = 1'b0; end
    @(negedge clk);
    check_eq("abort_start_busy", 32'(busy), 32'd0);
    check_eq("abort_start_read", 32'(READ), 32'd0);

    // 1: basic frame with latency checks
    d0 = done_cnt; p0 = pix_cnt;
    push_frame();
    pulse_start();
    @(negedge clk);
    check_eq("s1_read_c0", 32'(READ), 32'd1);
    check_eq("s1_valid_c0", 32'(pix_valid), 32'd0);
    check_eq("s1_busy_c0", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("s1_read_c1", 32'(READ), 32'd1);
    @(negedge clk);
    check_eq("s1_read_c2", 32'(READ), 32'd0);
    check_eq("s1_first_valid", 32'(pix_valid), 32'd1);
    check_eq("s1_first_data", 32'(pix_data), 32'h10);
    wait_frame("s1", 4, d0, p0);

    // 2: backpressure on pixel (0,1)
    pix_ready = 1'b0;
    d0 = done_cnt; p0 = pix_cnt;
    push_frame();
    pulse_start();
    wait_valid_row("s2_wait_row0", 0);
    @(posedge clk); #1 pix_ready = 1'b1;
    @(posedge clk); #1 pix_ready = 1'b0;
    @(negedge clk);
    check_eq("s2_stall_data", 32'(pix_data), 32'h11);
    check_eq("s2_stall_col", 32'(pix_col), 32'd1);
    check_eq("s2_stall_read", 32'(READ), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("s2_hold_data", 32'(pix_data), 32'h11);
    check_eq("s2_hold_valid", 32'(pix_valid), 32'd1);
    check_eq("s2_hold_read", 32'(READ), 32'd0);
    @(posedge clk); #1 pix_ready = 1'b1;
    wait_frame("s2", 4, d0, p0);

    // 3: start during STREAM is ignored
    d0 = done_cnt; p0 = pix_cnt;
    push_frame();
    pulse_start();
    wait_valid_row("s3_wait_row0", 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_frame("s3", 4, d0, p0);

    // 4: abort in the second SELECT cycle of row 1
    d0 = done_cnt;
    push_frame();
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (READ == 2'b10) break;
    end
    check_eq("s4_row1_select", 32'(READ), 32'd2);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_eq("s4_read", 32'(READ), 32'd0);
    check_eq("s4_busy", 32'(busy), 32'd0);
    check_eq("s4_valid", 32'(pix_valid), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check_eq("s4_no_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt; p0 = pix_cnt;
    push_frame();
    pulse_start();
    wait_frame("s4_replay", 4, d0, p0);

    // 5: asynchronous reset mid-STREAM
    push_frame();
    pulse_start();
    wait_valid_row("s5_wait_row0", 0);
    #2 reset = 1'b1;
    #1;
    check_eq("s5_read", 32'(READ), 32'd0);
    check_eq("s5_valid", 32'(pix_valid), 32'd0);
    check_eq("s5_busy", 32'(busy), 32'd0);
    sb_q.delete();
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    d0 = done_cnt; p0 = pix_cnt;
    push_frame();
    pulse_start();
    wait_frame("s5", 4, d0, p0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_readout.md
Name: pixel_readout

Overview:
- Readout controller on the far side of the pixel array's row-select / column-data interface.
- After a frame is converted, it walks the rows top to bottom, one row at a time:
  - drives a one-hot row-read strobe;
  - waits for the shared column bus to settle;
  - latches the full row;
  - streams it out pixel by pixel over a valid/ready handshake to the downstream frame sink.
- Sits between the pixel array and the sensor's output interface.
- Triggered by the top-level sensor state machine once conversion completes.

Parameters:
- HEIGHT, default PixelSensorConfig::PIXEL_ARRAY_HEIGHT (2): number of rows and the width of READ.
- WIDTH, default PixelSensorConfig::PIXEL_ARRAY_WIDTH (2): number of pixels per row on the column bus.
- BITS, default PixelSensorConfig::PIXEL_BITS (8): bits per pixel.
- SETTLE_CYCLES, default 2: cycles READ is held before capture; legal values 1..15.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to read out a frame; ignored unless idle.
- abort  input  1  synchronous cancel of the readout in progress.
- READ  output  HEIGHT  one-hot row-read strobe to the pixel array; registered output.
- DATA_IN  input  [WIDTH-1:0][BITS-1:0]  shared column data bus from the pixel array.
- pix_data  output  BITS  current pixel value.
- pix_valid  output  1  pix_data, pix_row, pix_col and pix_last are valid.
- pix_ready  input  1  downstream accepts the pixel.
- pix_row  output  $clog2(HEIGHT) (min 1)  row index of the current pixel.
- pix_col  output  $clog2(WIDTH) (min 1)  column index of the current pixel.
- pix_last  output  1  current pixel is the final pixel of the frame.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the frame readout completes.

Behaviour:
- Reset (asynchronous):
  - state = IDLE;
  - READ = 0 and all counters = 0;
  - pix_valid, pix_last, busy and done = 0;
  - row buffer = 0.
  - Taking effect mid-frame, READ drops immediately and no partial handshake survives.
- States: IDLE, SELECT, STREAM, DONE.
- IDLE:
  - start=1 → SELECT, with row=0 and settle counter=0.
  - In the SELECT cycles READ = 1 << row (registered, so it rises on the edge that enters SELECT).
- SELECT:
  - Lasts exactly SETTLE_CYCLES cycles.
  - On the edge ending the final SELECT cycle: row buffer ← DATA_IN, state → STREAM, READ → 0 on that same edge.
  - READ is therefore high for exactly SETTLE_CYCLES cycles, and DATA_IN is sampled while READ is still high.
- STREAM:
  - pix_valid = 1, with pix_data = buffer[col], pix_row = row, pix_col = col.
  - pix_last = (row==HEIGHT-1 && col==WIDTH-1).
  - While valid && !ready, all pixel outputs are held stable.
  - On a handshake (valid && ready) with col < WIDTH-1: col increments; the next pixel appears in the next cycle.
  - On a handshake with col == WIDTH-1 and row < HEIGHT-1: col=0, row increments, state → SELECT.
  - On a handshake with col == WIDTH-1 and row == HEIGHT-1: state → DONE.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - busy = 0 from the IDLE cycle onward.
- Latency:
  - start accepted at edge N → READ asserted from N.
  - First pix_valid appears SETTLE_CYCLES cycles after N.
  - With pix_ready held at 1, one pixel per cycle within a row, plus SETTLE_CYCLES of gap per row.
- start while busy: ignored, with no effect on the current frame.
- start in DONE: ignored. It is only accepted in IDLE.
- abort=1 in any non-IDLE state: next state is IDLE with READ=0, pix_valid=0, counters cleared, and no done pulse.
- abort together with a handshake: abort wins. The pixel counts as accepted downstream, but readout stops.
- abort in IDLE: no effect.
- abort and start in the same IDLE cycle: start is ignored.
- Counter widths are sized so no wrap occurs. row never exceeds HEIGHT-1 and col never exceeds WIDTH-1.
- READ is never multi-hot. It is all-zero outside SELECT.

Decomposition:
- PixelSensorConfig package holds:
  - PIXEL_ARRAY_HEIGHT, PIXEL_ARRAY_WIDTH, PIXEL_BITS;
  - the readout_state_t enum {IDLE, SELECT, STREAM, DONE};
  - a pixel_t typedef of logic [PIXEL_BITS-1:0].
- No sub-module. The FSM, settle counter, row buffer and output mux fit one module.
- Optional sub-module: pixel_row_buffer (capture register plus column mux) if reuse is wanted.

Test Plan:
1. HEIGHT=2, WIDTH=2, SETTLE=2, pix_ready=1. Bench models the array: READ[0] → DATA_IN={8'h11,8'h10}, READ[1] → {8'h21,8'h20}. Pulse start.
   - Required: READ=01 for 2 cycles, then stream 10,11.
   - READ=10 for 2 cycles, then stream 20,21.
   - pix_last only on 21; done pulses 1 cycle later.
2. Backpressure: same data, pix_ready=0 for 3 cycles on pixel (0,1).
   - Required: pix_data=11 and pix_col=1 held stable, READ stays 0, order unchanged.
3. start pulsed during STREAM of row 0.
   - Required: ignored; exactly 4 pixels and one done pulse.
4. abort asserted in the second SELECT cycle of row 1.
   - Required: next cycle READ=0, busy=0, pix_valid=0, no done pulse.
   - A fresh start then replays from row 0 starting with 10.
5. Asynchronous reset asserted mid-STREAM, off the clock edge.
   - Required: READ, pix_valid and busy go to 0 immediately.
   - After release, start yields a correct full frame.
6. Assertions throughout all scenarios:
   - READ is one-hot or zero;
   - READ is high exactly SETTLE_CYCLES cycles per row;
   - DATA_IN is sampled only while READ is nonzero.
